// File: rtl/repsub_divider.sv
// Unsigned divider that uses repeated subtraction: one subtract per clock, so the latency grows with the quotient.
// A zero divisor skips the loop and reports all-ones / zero with a flag.
module repsub_divider #(
  parameter int DSR_W = 3,
  parameter int DVD_W = 2 * DSR_W
) (
  input  logic             SYS_CLOCK,
  input  logic             SYS_RESET_N,
  input  logic             START,
  input  logic [DVD_W-1:0] DIVIDEND,
  input  logic [DSR_W-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [DVD_W-1:0] QUOTIENT,
  output logic [DSR_W-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [DVD_W-1:0] Q_ONE = DVD_W'(1);

  logic [1:0]       r_state;
  logic [DVD_W-1:0] r_rem;
  logic [DSR_W-1:0] r_dsr;
  logic [DVD_W-1:0] r_qcnt;
  logic [DVD_W-1:0] r_quo;
  logic [DSR_W-1:0] r_rmd;
  logic             r_dz;

  logic [DVD_W-1:0] w_dsr_ext;
  logic             w_ge;

  // The compare runs at full dividend width, so the subtraction can never underflow.
  assign w_dsr_ext = {{(DVD_W-DSR_W){1'b0}}, r_dsr};
  assign w_ge      = (r_rem >= w_dsr_ext);

  always_ff @(posedge SYS_CLOCK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dsr   <= '0;
      r_qcnt  <= '0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            if (DIVISOR == '0) begin
              r_quo   <= '1;
              r_rmd   <= '0;
              r_dz    <= 1'b1;
              r_state <= FIN;
            end else begin
              r_rem   <= DIVIDEND;
              r_dsr   <= DIVISOR;
              r_qcnt  <= '0;
              r_state <= SUB;
            end
          end
        end
        SUB: begin
          if (w_ge) begin
            r_rem  <= r_rem - w_dsr_ext;
            r_qcnt <= r_qcnt + Q_ONE;
          end else begin
            r_quo   <= r_qcnt;
            r_rmd   <= r_rem[DSR_W-1:0];
            r_dz    <= 1'b0;
            r_state <= FIN;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY        = (r_state != IDLE);
  assign DONE        = (r_state == FIN);
  assign QUOTIENT    = r_quo;
  assign REMAINDER   = r_rmd;
  assign DIV_BY_ZERO = r_dz;

endmodule

// File: tb/tb_repsub_divider.sv
// Directed bench for repsub_divider at the default width (6-bit dividend, 3-bit divisor).
// The expected quotients, remainders and DONE latencies are worked out by hand.
module tb_repsub_divider;
  localparam int DSR_W = 3;
  localparam int DVD_W = 6;

  logic             SYS_CLOCK = 1'b0;
  logic             SYS_RESET_N;
  logic             START;
  logic [DVD_W-1:0] DIVIDEND;
  logic [DSR_W-1:0] DIVISOR;
  logic             BUSY, DONE, DIV_BY_ZERO;
  logic [DVD_W-1:0] QUOTIENT;
  logic [DSR_W-1:0] REMAINDER;

  int n_chk  = 0;
  int n_pass = 0;

  repsub_divider #(.DSR_W(DSR_W)) dut (
    .SYS_CLOCK(SYS_CLOCK), .SYS_RESET_N(SYS_RESET_N), .START(START),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .BUSY(BUSY), .DONE(DONE),
    .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER), .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // Called 1 time unit after E0; k ends as the index of the edge after which DONE rose.
  task automatic wait_done(input string tag, output int k);
    k = 0;
    while (!DONE && k < 200) begin
      @(posedge SYS_CLOCK); #1;
      k++;
    end
    if (!DONE) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run(input string tag, input int dvd, input int dsr,
                     input int eq, input int er, input int edz, input int elat);
    int k;
    DIVIDEND = DVD_W'(dvd);
    DIVISOR  = DSR_W'(dsr);
    START    = 1'b1;
    @(posedge SYS_CLOCK); #1;
    START = 1'b0;
    chk({tag, "_busy"}, BUSY, 1);
    wait_done(tag, k);
    chk({tag, "_lat"}, k, elat);
    chk({tag, "_q"}, QUOTIENT, eq);
    chk({tag, "_r"}, REMAINDER, er);
    chk({tag, "_dz"}, DIV_BY_ZERO, edz);
    @(posedge SYS_CLOCK); #1;
    chk({tag, "_done_pulse"}, DONE, 0);
    chk({tag, "_idle"}, BUSY, 0);
  endtask

  initial begin
    int k;
    SYS_RESET_N = 1'b0;
    START = 1'b0; DIVIDEND = '0; DIVISOR = '0;
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_q", QUOTIENT, 0);
    chk("rst_r", REMAINDER, 0);
    chk("rst_dz", DIV_BY_ZERO, 0);
    // Keep reset asserted across a few edges.
    repeat (2) @(posedge SYS_CLOCK);
    #1 SYS_RESET_N = 1'b1;

    run("d42_5", 42, 5, 8, 2, 0, 9);
    // The result must hold while the block sits idle.
    repeat (3) @(posedge SYS_CLOCK); #1;
    chk("hold_q", QUOTIENT, 8);
    chk("hold_r", REMAINDER, 2);
    run("d5_6",  5, 6, 0, 5, 0, 1);
    run("d63_1", 63, 1, 63, 0, 0, 64);
    run("d17_0", 17, 0, 63, 0, 1, 0);
    run("d12_4", 12, 4, 3, 0, 0, 4);

    // START stays high and DIVIDEND changes while 42/5 is running.
    DIVIDEND = 6'd42; DIVISOR = 3'd5; START = 1'b1;
    @(posedge SYS_CLOCK); #1;
    DIVIDEND = 6'd9;
    wait_done("hold_start", k);
    chk("hs_lat", k, 9);
    chk("hs_q", QUOTIENT, 8);
    chk("hs_r", REMAINDER, 2);
    @(posedge SYS_CLOCK); #1;
    chk("hs_idle", BUSY, 0);
    @(posedge SYS_CLOCK); #1;
    START = 1'b0;
    chk("hs_restart", BUSY, 1);
    wait_done("hold_start2", k);
    chk("hs2_lat", k, 2);
    chk("hs2_q", QUOTIENT, 1);
    chk("hs2_r", REMAINDER, 4);
    @(posedge SYS_CLOCK); #1;

    // Reset in the middle of 63/1. QUOTIENT and REMAINDER still hold 1 and 4 from the last operation.
    DIVIDEND = 6'd63; DIVISOR = 3'd1; START = 1'b1;
    @(posedge SYS_CLOCK); #1;
    START = 1'b0;
    repeat (20) @(posedge SYS_CLOCK);
    #2 SYS_RESET_N = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_done", DONE, 0);
    chk("arst_q", QUOTIENT, 0);
    chk("arst_r", REMAINDER, 0);
    chk("arst_dz", DIV_BY_ZERO, 0);
    DIVIDEND = 6'd12; DIVISOR = 3'd4; START = 1'b1;
    repeat (2) @(posedge SYS_CLOCK); #1;
    chk("rst_ignore_start", BUSY, 0);
    START = 1'b0;
    SYS_RESET_N = 1'b1;
    repeat (3) @(posedge SYS_CLOCK); #1;
    chk("post_rst_no_done", DONE, 0);
    run("post_rst_12_4", 12, 4, 3, 0, 0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/repsub_divider.md
REPSUB_DIVIDER -- requirements
Module: repsub_divider

Interface
REQ-001 Parameter: DSR_W, default 3, divisor/remainder width; dividend/quotient width is DVD_W = 2*DSR_W (6 at default).
REQ-002 SYS_CLOCK  in  1  single clock; all state changes on its rising edge.
REQ-003 SYS_RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 START  in  1  request; sampled only in IDLE.
REQ-005 DIVIDEND  in  DVD_W  unsigned numerator; captured on the edge that accepts START.
REQ-006 DIVISOR  in  DSR_W  unsigned denominator; captured on the same edge.
REQ-007 BUSY  out  1  high in every state except IDLE.
REQ-008 DONE  out  1  one-cycle completion pulse.
REQ-009 QUOTIENT  out  DVD_W  registered result.
REQ-010 REMAINDER  out  DSR_W  registered result.
REQ-011 DIV_BY_ZERO  out  1  registered flag for the last completed operation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SUB, FIN.
REQ-013 IDLE, START=1, DIVISOR!=0: the block SHALL load R_REG (DVD_W) <= DIVIDEND, B_REG <= DIVISOR, Q_CNT <= 0, and go to SUB.
REQ-014 IDLE, START=1, DIVISOR==0: the block SHALL go directly to FIN, loading QUOTIENT = all ones, REMAINDER = 0, DIV_BY_ZERO = 1.
REQ-015 SUB, R_REG >= zero-extended B_REG: R_REG <= R_REG - B_REG, Q_CNT <= Q_CNT + 1, stay in SUB.
REQ-016 SUB, R_REG < B_REG: the block SHALL go to FIN, loading QUOTIENT <= Q_CNT, REMAINDER <= R_REG[DSR_W-1:0], DIV_BY_ZERO <= 0.
REQ-017 The comparison SHALL be unsigned and full-width; the subtraction never underflows; Q_CNT never wraps (max 2^DVD_W-1).
REQ-018 FIN SHALL assert DONE for exactly one cycle, then go to IDLE unconditionally.
REQ-019 Latency: with START accepted on edge E0 and quotient q, DONE SHALL be high in the cycle after edge E(q+1); divide-by-zero: the cycle after E0.
REQ-020 START in SUB or FIN SHALL be ignored, with no queuing; START held high SHALL begin a new operation on the first IDLE cycle.
REQ-021 DIVIDEND/DIVISOR changes after the capture edge SHALL NOT affect the running operation.
REQ-022 QUOTIENT, REMAINDER and DIV_BY_ZERO SHALL hold their values until the next transition into FIN.
REQ-023 BUSY SHALL be low in IDLE and high in SUB and FIN.

Reset
REQ-024 SYS_RESET_N=0 SHALL immediately, without a clock, force state IDLE, BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_BY_ZERO=0, and R_REG/B_REG/Q_CNT=0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation with no DONE pulse; the first START after release SHALL be accepted normally.
REQ-026 START SHALL be ignored while SYS_RESET_N=0.

Verification
REQ-027 42/5: START at E0 -> DONE in the cycle after E9, QUOTIENT=8, REMAINDER=2, DIV_BY_ZERO=0, BUSY high from E0 until after E10.
REQ-028 5/6: -> DONE in the cycle after E1, QUOTIENT=0, REMAINDER=5.
REQ-029 63/1: -> DONE in the cycle after E64, QUOTIENT=63, REMAINDER=0 (maximum latency, no counter wrap).
REQ-030 17/0: -> DONE in the cycle after E0, DIV_BY_ZERO=1, QUOTIENT=63, REMAINDER=0; a following 12/4 clears DIV_BY_ZERO and gives QUOTIENT=3, REMAINDER=0.
REQ-031 START held high with DIVIDEND changed to 9 during a 42/5 run -> result still 8 r2; the second operation, 9/5, starts in the IDLE cycle after DONE -> 1 r4.
REQ-032 SYS_RESET_N pulsed low at cycle 20 of 63/1 -> all outputs 0 asynchronously, no DONE; after release, 12/4 -> QUOTIENT=3, REMAINDER=0.
